uart_rx: RTL and testbench

Serial receiver for the 8N1 UART link; the receive-side counterpart of `UART_TX`, sharing its `CLKS_PER_BIT` baud parameter.

- Synchronises the asynchronous `i_RX_Serial` line and detects start bits.
- Samples every bit at its centre and checks the stop bit.
- Delivers each good byte with a one-cycle valid strobe, or flags a framing error.
- Sits between the board RX pin and the message-assembly logic upstream of the hashing core.

---
 rtl/uart_rx.sv | 121 ++++++++++++
 tb/tb_uart_rx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, centre-of-bit sampling, stop-bit check.
// Good bytes come out with a one-cycle o_RX_DV strobe; a low stop bit gives a one-cycle o_Frame_Err.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Active,
    output logic       o_Frame_Err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP, BREAK} state_t;

    state_t          state;
    logic            meta;
    logic            sync;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [7:0]      shift_reg;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
        end else begin
            meta <= i_RX_Serial;
            sync <= meta;
        end
    end

    // o_RX_Active is loaded with the membership of the next state, so it always
    // equals "state is START, DATA, STOP or BREAK" while staying a plain flop.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift_reg   <= '0;
            o_RX_DV     <= 1'b0;
            o_RX_Byte   <= '0;
            o_RX_Active <= 1'b0;
            o_Frame_Err <= 1'b0;
        end else begin
            o_RX_DV     <= 1'b0;
            o_Frame_Err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!sync) begin
                        state       <= START;
                        o_RX_Active <= 1'b1;
                    end
                end
                START: begin
                    if (cnt != HALF) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (!sync) begin
                            state <= DATA;
                        end else begin
                            state       <= IDLE;
                            o_RX_Active <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (cnt != LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt            <= '0;
                        shift_reg[idx] <= sync;
                        if (idx == 3'd7) begin
                            idx   <= '0;
                            state <= STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (cnt != LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (sync) begin
                            o_RX_Byte   <= shift_reg;
                            o_RX_DV     <= 1'b1;
                            o_RX_Active <= 1'b0;
                            state       <= CLEANUP;
                        end else begin
                            // Held-low line: wait for idle instead of reading 0x00 frames.
                            o_Frame_Err <= 1'b1;
                            state       <= BREAK;
                        end
                    end
                end
                CLEANUP: begin
                    state <= IDLE;
                end
                BREAK: begin
                    if (sync) begin
                        state       <= IDLE;
                        o_RX_Active <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    o_RX_Active <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a line-history receiver model predicts every output each cycle,
// plus directed frames with hand-computed strobe times and a single C=434 byte.
module tb_uart_rx;
    localparam int C    = 8;
    localparam int H    = (C - 1) / 2;
    localparam int CL   = 434;
    localparam int MAXC = 80000;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       line  = 1'b1;
    logic       line2 = 1'b1;
    logic       dv, ferr, act, dv2, ferr2, act2;
    logic [7:0] rbyte, rbyte2;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(line),
        .o_RX_DV(dv), .o_RX_Byte(rbyte), .o_RX_Active(act), .o_Frame_Err(ferr)
    );

    uart_rx #(.CLKS_PER_BIT(CL)) dut_slow (
        .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(line2),
        .o_RX_DV(dv2), .o_RX_Byte(rbyte2), .o_RX_Active(act2), .o_Frame_Err(ferr2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // L[m]: line value captured by the first synchroniser flop at edge m.
    bit L [MAXC];
    bit act_hist [MAXC];

    int total = 0;
    int bad   = 0;

    bit         in_frame, breaking;
    int         s, ready;
    logic       exp_dv, exp_err, exp_act;
    logic [7:0] exp_byte;

    int         dv_cnt = 0, err_cnt = 0, act_cnt = 0, err_cyc = 0, exp_dv_cyc = 0;
    int         dv_cyc_q[$];
    logic [7:0] dv_byte_q[$];
    int         dv2_cnt = 0, dv2_cyc = 0;
    logic [7:0] dv2_byte = 8'h00;
    int         drv_cyc = 0;

    // Value the receiver sees on its sync line at edge m.
    function automatic bit S(int m);
        if (m < 2) return 1'b1;
        return L[m-2];
    endfunction

    function automatic logic [7:0] assemble(int st);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = S(st + 1 + H + (k + 1) * C);
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            if (bad <= 30) $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin : model
        int n;
        n = cyc;
        if (n + 1 < MAXC) L[n+1] = line;
        exp_dv  = 1'b0;
        exp_err = 1'b0;
        if (rst) begin
            if (n >= 1) L[n-1] = 1'b1;
            L[n] = 1'b1;
            if (n + 1 < MAXC) L[n+1] = 1'b1;
            in_frame = 1'b0;
            breaking = 1'b0;
            exp_byte = 8'h00;
            ready    = n + 1;
        end else if (!in_frame) begin
            if (n >= ready && !S(n)) begin
                in_frame = 1'b1;
                s        = n;
            end
        end else if (breaking) begin
            if (S(n)) begin
                in_frame = 1'b0;
                breaking = 1'b0;
                ready    = n + 1;
            end
        end else if (n == s + 1 + H) begin
            if (S(n)) begin
                in_frame = 1'b0;
                ready    = n + 1;
            end
        end else if (n == s + 1 + H + 9 * C) begin
            if (S(n)) begin
                exp_dv   = 1'b1;
                exp_byte = assemble(s);
                in_frame = 1'b0;
                ready    = n + 2;
            end else begin
                exp_err  = 1'b1;
                breaking = 1'b1;
            end
        end
        exp_act = in_frame;

        chk("dv", dv, exp_dv);
        chk("frame_err", ferr, exp_err);
        chk("active", act, exp_act);
        chk("byte", rbyte, exp_byte);

        if (n < MAXC) act_hist[n] = act;
        if (dv) begin
            dv_cnt++;
            dv_cyc_q.push_back(n);
            dv_byte_q.push_back(rbyte);
        end
        if (ferr) begin
            err_cnt++;
            err_cyc = n;
        end
        if (act) act_cnt++;
        if (exp_dv) exp_dv_cyc = n;
        if (dv2) begin
            dv2_cnt++;
            dv2_cyc  = n;
            dv2_byte = rbyte2;
        end
    end

    // Line holds v for exactly n capturing edges, starting at edge drv_cyc+1.
    task automatic hold(input logic v, input int n);
        @(posedge clk);
        #1;
        line    = v;
        drv_cyc = cyc;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
        hold(1'b0, C);
        t0 = drv_cyc + 1;
        for (int k = 0; k < 8; k++) hold(b[k], C);
        hold(stop, C);
    endtask

    task automatic send_slow(input logic [7:0] b, output int t0);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            line2 = fr[k];
            if (k == 0) t0 = cyc + 1;
            repeat (CL - 1) @(posedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         t0, t1, d0, e0, q0, r;
        logic [7:0] b;
        logic [7:0] pat;

        repeat (4) @(posedge clk);
        #1;
        chk("rst_byte", rbyte, 8'h00);
        chk("rst_dv", dv, 1'b0);
        chk("rst_active", act, 1'b0);
        chk("rst_err", ferr, 1'b0);
        @(posedge clk);
        #3 rst = 1'b0;
        hold(1'b1, 20);

        // Clean 0xA5: strobe right after edge T0+78; Active is low in the strobe cycle.
        d0 = dv_cnt; e0 = err_cnt;
        send_frame(8'hA5, 1'b1, t0);
        hold(1'b1, 20);
        chk("clean_count", dv_cnt - d0, 1);
        chk("clean_cycle", dv_cyc_q[dv_cyc_q.size()-1], t0 + 78);
        chk("clean_byte", dv_byte_q[dv_byte_q.size()-1], 8'hA5);
        chk("model_cycle", exp_dv_cyc, t0 + 78);
        chk("clean_err", err_cnt - e0, 0);
        chk("clean_act_hi", act_hist[t0+77], 1'b1);
        chk("clean_act_lo", act_hist[t0+78], 1'b0);

        // Two-cycle glitch: Active for H+1 cycles, nothing else.
        d0 = dv_cnt; e0 = err_cnt; act_cnt = 0;
        hold(1'b0, 2);
        hold(1'b1, 20);
        chk("glitch_active", act_cnt, H + 1);
        chk("glitch_dv", dv_cnt - d0, 0);
        chk("glitch_err", err_cnt - e0, 0);
        chk("glitch_byte", rbyte, 8'hA5);

        // 0x3C with low stop, line held low, then released.
        d0 = dv_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b0, t0);
        hold(1'b0, 40);
        hold(1'b1, 20);
        r = drv_cyc;
        chk("ferr_count", err_cnt - e0, 1);
        chk("ferr_cycle", err_cyc, t0 + 78);
        chk("ferr_dv", dv_cnt - d0, 0);
        chk("ferr_byte", rbyte, 8'hA5);
        chk("ferr_act_hi", act_hist[r+2], 1'b1);
        chk("ferr_act_lo", act_hist[r+3], 1'b0);

        // Back-to-back 0x00 then 0xFF with a single stop bit.
        q0 = dv_cyc_q.size();
        send_frame(8'h00, 1'b1, t0);
        send_frame(8'hFF, 1'b1, t1);
        hold(1'b1, 20);
        chk("b2b_count", dv_cyc_q.size() - q0, 2);
        if (dv_cyc_q.size() - q0 == 2) begin
            chk("b2b_gap", dv_cyc_q[q0+1] - dv_cyc_q[q0], 10 * C);
            chk("b2b_byte0", dv_byte_q[q0], 8'h00);
            chk("b2b_byte1", dv_byte_q[q0+1], 8'hFF);
        end

        // Reset asserted between edges during data bit 3 of 0x5A.
        d0 = dv_cnt; e0 = err_cnt;
        pat = 8'h5A;
        hold(1'b0, C);
        for (int k = 0; k < 3; k++) hold(pat[k], C);
        @(posedge clk);
        #1 line = pat[3];
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_byte", rbyte, 8'h00);
        chk("midrst_active", act, 1'b0);
        chk("midrst_dv", dv, 1'b0);
        chk("midrst_err", ferr, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        hold(1'b1, 12);
        send_frame(8'h81, 1'b1, t0);
        hold(1'b1, 20);
        chk("postrst_count", dv_cnt - d0, 1);
        chk("postrst_err", err_cnt - e0, 0);
        chk("postrst_byte", dv_byte_q[dv_byte_q.size()-1], 8'h81);
        chk("postrst_cycle", dv_cyc_q[dv_cyc_q.size()-1], t0 + 78);

        // Random traffic: frames, bad stops, glitches, breaks and stray resets.
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 75) begin
                b = 8'($urandom);
                send_frame(b, ($urandom_range(0, 9) != 0), t0);
                if ($urandom_range(0, 3) != 0) hold(1'b1, $urandom_range(1, 12));
            end else if (r < 87) begin
                hold(1'b0, $urandom_range(1, 6));
                hold(1'b1, $urandom_range(1, 15));
            end else if (r < 97) begin
                hold(1'b0, $urandom_range(12, 90));
                hold(1'b1, $urandom_range(1, 15));
            end else begin
                @(posedge clk);
                #3 rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #3 rst = 1'b0;
            end
        end
        hold(1'b1, 30);

        // One byte at the default 115200 baud divisor.
        send_slow(8'h0F, t0);
        repeat (300) @(posedge clk);
        #1;
        chk("slow_count", dv2_cnt, 1);
        chk("slow_cycle", dv2_cyc, t0 + 4125);
        chk("slow_byte", dv2_byte, 8'h0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
